// File: rtl/dsp_chain_pkg.sv
// ============================================================================
// Package  : dsp_chain_pkg
// Brief    : shared widths and buffer-state encoding for the fp16 loader
// Revision : 1.0
// ============================================================================
`default_nettype none

package dsp_chain_pkg;

  localparam int BEAT_W  = 128;            // 8 fp16 operands per beat
  localparam int LANES   = 8;              // beats per frame, one per sop2 lane
  localparam int FRAME_W = BEAT_W * LANES;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/dsp_chain_frame_buf.sv
// ============================================================================
// Module   : dsp_chain_frame_buf
// Brief    : two-entry frame FIFO; head data is read straight from storage
// Revision : 1.0
// ============================================================================
`default_nettype none

module dsp_chain_frame_buf #(
  parameter int FRAME_W = dsp_chain_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] push_data,
  output logic               full,
  output logic               empty,
  output logic [FRAME_W-1:0] head_data
);

  logic [FRAME_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dsp_chain_2_fp16_operand_loader_8.sv
// ============================================================================
// Module   : dsp_chain_2_fp16_operand_loader_8
// Brief    : gathers LANES beats into one frame for the 8-lane sop2 array
// Revision : 1.0
// ============================================================================
`default_nettype none

module dsp_chain_2_fp16_operand_loader_8 #(
  parameter int BEAT_W = dsp_chain_pkg::BEAT_W,
  parameter int LANES  = dsp_chain_pkg::LANES,
  parameter int CNT_W  = dsp_chain_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [BEAT_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [BEAT_W*LANES-1:0]   m_data,
  output logic                      err_short,
  output logic                      err_long,
  output logic [CNT_W-1:0]          frame_cnt
);

  localparam int             FRAME_W   = BEAT_W * LANES;
  localparam int             ASM_W     = BEAT_W * (LANES - 1);
  localparam int             BC_W      = $clog2(LANES);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(LANES - 1);

  import dsp_chain_pkg::*;

  buf_state_t         state;
  buf_state_t         state_nxt;
  logic [BC_W-1:0]    beat_cnt;
  logic [BC_W-1:0]    beat_cnt_nxt;
  logic [ASM_W-1:0]   asm_q;
  logic [FRAME_W-1:0] commit_data;
  logic               last_beat;
  logic               accept;
  logic               commit;
  logic               drop;
  logic               retire;
  logic               buf_full;
  logic               buf_empty;

  // The final beat bypasses the assembly register and lands directly in the buffer.
  assign commit_data = {s_data, asm_q};

  always_comb begin
    last_beat    = (beat_cnt == LAST_BEAT);
    accept       = s_valid && s_ready;
    commit       = accept && last_beat;
    drop         = accept && s_last && !last_beat;
    retire       = m_valid && m_ready;
    beat_cnt_nxt = beat_cnt;
    if (accept) begin
      beat_cnt_nxt = (commit || drop) ? '0 : beat_cnt + 1'b1;
    end
    state_nxt = state;
    case (state)
      ST_EMPTY: if (commit)                state_nxt = ST_ONE;
      ST_ONE:   if (commit && !retire)     state_nxt = ST_FULL;
                else if (!commit && retire) state_nxt = ST_EMPTY;
      ST_FULL:  if (retire && !commit)     state_nxt = ST_ONE;
      default:                             state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake outputs are computed from next-state so they leave a flop each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      beat_cnt  <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      s_ready   <= (state_nxt != ST_FULL) || (beat_cnt_nxt != LAST_BEAT);
      m_valid   <= (state_nxt != ST_EMPTY);
      err_short <= drop;
      err_long  <= commit && !s_last;
      if (retire) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q <= '0;
    end else if (accept && !last_beat) begin
      asm_q[int'(beat_cnt)*BEAT_W +: BEAT_W] <= s_data;
    end
  end

  dsp_chain_frame_buf #(
    .FRAME_W   (FRAME_W)
  ) u_frame_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (commit),
    .pop       (retire),
    .push_data (commit_data),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_data (m_data)
  );

  // Occupancy FSM and buffer pointers must never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (((state == ST_FULL) == buf_full) && ((state == ST_EMPTY) == buf_empty));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsp_chain_2_fp16_operand_loader_8.sv
// ============================================================================
// Module   : tb_dsp_chain_2_fp16_operand_loader_8
// Brief    : directed self-checking bench for the fp16 operand loader
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dsp_chain_2_fp16_operand_loader_8;

  localparam int BEAT_W  = 128;
  localparam int LANES   = 8;
  localparam int FRAME_W = BEAT_W * LANES;
  localparam int CNT_W   = 4;   // narrow counter so the wrap is reachable quickly

  logic               clk;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic [BEAT_W-1:0]  s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [FRAME_W-1:0] m_data;
  logic               err_short;
  logic               err_long;
  logic [CNT_W-1:0]   frame_cnt;

  int total;
  int bad;
  int stalls;

  dsp_chain_2_fp16_operand_loader_8 #(
    .BEAT_W    (BEAT_W),
    .LANES     (LANES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_short (err_short),
    .err_long  (err_long),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat_val(input int f, input int k);
    return BEAT_W'((f << 8) | (k + 1));
  endfunction

  function automatic logic [FRAME_W-1:0] frame_val(input int f);
    logic [FRAME_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*BEAT_W +: BEAT_W] = beat_val(f, k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves s_valid high so consecutive calls stream one beat per cycle.
  task automatic put_beat(input logic [BEAT_W-1:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    stalls += n;
    if (n >= 50) check("s_ready_timeout", s_ready, 1'b1);
    tick();
  endtask

  task automatic send_frame(input int f, input int nbeats, input int last_at);
    for (int k = 0; k < nbeats; k++) put_beat(beat_val(f, k), k == last_at);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    stalls  = 0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_s_ready",   s_ready,   1'b0);
    check("rst_m_valid",   m_valid,   1'b0);
    check("rst_m_data",    m_data,    '0);
    check("rst_err_short", err_short, 1'b0);
    check("rst_err_long",  err_long,  1'b0);
    check("rst_frame_cnt", frame_cnt, 4'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rel_s_ready_before_edge", s_ready, 1'b0);
    tick();
    check("rel_s_ready_after_edge", s_ready, 1'b1);

    // Basic frame, beats 1..8, m_ready high
    m_ready = 1'b1;
    send_frame(0, 8, 7);
    s_valid = 1'b0;
    check("t1_m_valid",   m_valid,           1'b1);
    check("t1_m_data",    m_data,            frame_val(0));
    check("t1_low_beat",  m_data[127:0],     128'h1);
    check("t1_high_beat", m_data[1023:896],  128'h8);
    check("t1_err_long",  err_long,          1'b0);
    tick();
    check("t1_frame_cnt", frame_cnt, 4'd1);
    check("t1_drained",   m_valid,   1'b0);

    // Back-pressure: three frames with m_ready low
    m_ready = 1'b0;
    send_frame(1, 8, 7);
    send_frame(2, 8, 7);
    send_frame(3, 7, -1);
    s_data = beat_val(3, 7);
    s_last = 1'b1;
    check("t2_full_blocks_last", s_ready, 1'b0);
    tick();
    tick();
    check("t2_still_blocked", s_ready, 1'b0);
    check("t2_m_valid",       m_valid, 1'b1);
    check("t2_head_f1",       m_data,  frame_val(1));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t2_cnt_after_f1",  frame_cnt, 4'd2);
    check("t2_head_f2",       m_data,    frame_val(2));
    check("t2_slot_freed",    s_ready,   1'b1);
    put_beat(beat_val(3, 7), 1'b1);
    s_valid = 1'b0;
    check("t2_hold_f2",       m_data,    frame_val(2));
    check("t2_hold_valid",    m_valid,   1'b1);
    m_ready = 1'b1;
    tick();
    check("t2_head_f3",       m_data,    frame_val(3));
    check("t2_cnt_after_f2",  frame_cnt, 4'd3);
    tick();
    check("t2_empty",         m_valid,   1'b0);
    check("t2_cnt_after_f3",  frame_cnt, 4'd4);

    // Early s_last on beat 3 drops the frame
    send_frame(4, 4, 3);
    s_valid = 1'b0;
    check("t3_err_short",     err_short, 1'b1);
    check("t3_no_m_valid",    m_valid,   1'b0);
    tick();
    check("t3_err_short_end", err_short, 1'b0);
    send_frame(5, 8, 7);
    s_valid = 1'b0;
    check("t3_next_valid",    m_valid,   1'b1);
    check("t3_next_data",     m_data,    frame_val(5));
    check("t3_no_err_long",   err_long,  1'b0);
    tick();
    check("t3_frame_cnt",     frame_cnt, 4'd5);

    // Missing s_last still delivers, flags err_long
    send_frame(6, 8, -1);
    s_valid = 1'b0;
    check("t4_err_long",      err_long,  1'b1);
    check("t4_m_data",        m_data,    frame_val(6));
    check("t4_m_valid",       m_valid,   1'b1);
    tick();
    check("t4_err_long_end",  err_long,  1'b0);
    check("t4_frame_cnt",     frame_cnt, 4'd6);

    // Reset mid-operation with one frame buffered and a partial frame
    m_ready = 1'b0;
    send_frame(7, 8, 7);
    send_frame(8, 6, -1);
    s_valid = 1'b0;
    check("t5_buffered", m_valid, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("t5_async_s_ready",   s_ready,   1'b0);
    check("t5_async_m_valid",   m_valid,   1'b0);
    check("t5_async_m_data",    m_data,    '0);
    check("t5_async_err_short", err_short, 1'b0);
    check("t5_async_err_long",  err_long,  1'b0);
    check("t5_async_frame_cnt", frame_cnt, 4'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    m_ready = 1'b1;
    tick();
    check("t5_ready_after_rel", s_ready, 1'b1);
    send_frame(9, 8, 7);
    s_valid = 1'b0;
    check("t5_frame_data",  m_data,    frame_val(9));
    check("t5_frame_valid", m_valid,   1'b1);
    tick();
    check("t5_frame_cnt",   frame_cnt, 4'd1);

    // Sustained streaming to wrap the frame counter
    stalls = 0;
    for (int f = 10; f < 25; f++) begin
      send_frame(f, 8, 7);
      check($sformatf("t6_data_f%0d", f), m_data, frame_val(f));
    end
    check("t6_cnt_max", frame_cnt, 4'hf);
    s_valid = 1'b0;
    check("t6_no_stalls", 32'(stalls), 32'd0);
    tick();
    check("t6_cnt_wrap", frame_cnt, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dsp_chain_2_fp16_operand_loader_8.md
DSP_CHAIN_2_FP16_OPERAND_LOADER_8 -- requirements
Module: dsp_chain_2_fp16_operand_loader_8

Interface
REQ-001 SHALL have parameter BEAT_W, default 128, beat width in bits (8 fp16 operands, one sop2 instance).
REQ-002 SHALL have parameter LANES, default 8, beats per frame (one per downstream instance).
REQ-003 SHALL have parameter CNT_W, default 16, frame counter width.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  in  1  input beat valid.
REQ-007 SHALL have port s_ready  out  1  loader can accept a beat.
REQ-008 SHALL have port s_data  in  BEAT_W  input beat payload.
REQ-009 SHALL have port s_last  in  1  producer marks final beat of frame.
REQ-010 SHALL have port m_valid  out  1  assembled frame available.
REQ-011 SHALL have port m_ready  in  1  downstream takes frame.
REQ-012 SHALL have port m_data  out  BEAT_W*LANES  assembled frame, drives the 1024-bit inp of the 8-lane sop2 module.
REQ-013 SHALL have port err_short  out  1  one-cycle pulse, frame dropped (early s_last).
REQ-014 SHALL have port err_long  out  1  one-cycle pulse, frame committed without s_last.
REQ-015 SHALL have port frame_cnt  out  CNT_W  count of frames delivered on m side.

Function
REQ-016 SHALL accept a beat only on s_valid && s_ready at a rising clk edge.
REQ-017 SHALL write accepted beat k (k = beat counter 0..LANES-1) to frame bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k].
REQ-018 SHALL increment beat counter per accepted beat; on beat LANES-1 commit frame to 2-entry frame buffer and return counter to 0.
REQ-019 SHALL drop the partial frame, return counter to 0 and pulse err_short for the cycle after acceptance when s_last is accepted on beat k < LANES-1.
REQ-020 SHALL commit the frame and pulse err_long for the cycle after acceptance when beat LANES-1 is accepted with s_last low.
REQ-021 SHALL assert m_valid the cycle after the committing beat is accepted (latency 1 cycle).
REQ-022 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-023 SHALL retire the head frame on m_valid && m_ready and increment frame_cnt, wrapping 2^CNT_W-1 -> 0.
REQ-024 SHALL run buffer occupancy FSM with states EMPTY, ONE, FULL: commit moves up, retire moves down, simultaneous commit and retire holds state.
REQ-025 SHALL drive s_ready = 1 in EMPTY and ONE; in FULL s_ready = 1 only while beat counter < LANES-1 (final beat blocked until a slot frees).
REQ-026 SHALL derive s_ready and m_valid from registered state only; no combinational path m_ready -> s_ready.
REQ-027 SHALL deliver frames in commit order; sustain one beat per cycle with m_ready held high.

Reset
REQ-028 SHALL on reset low immediately clear: s_ready=0, m_valid=0, m_data=0, err_short=0, err_long=0, frame_cnt=0, beat counter=0, FSM=EMPTY.
REQ-029 SHALL discard any partial or buffered frame on reset mid-operation; s_ready goes 1 on first clk edge after reset release.

Structure
REQ-030 SHALL take BEAT_W, LANES, FRAME_W and the FSM state enum from shared package dsp_chain_pkg.
REQ-031 SHALL implement the 2-entry frame storage as sub-module dsp_chain_frame_buf (push, pop, full, empty, head data).

Verification
REQ-032 SHALL cover: 8 beats 0x...01..0x...08, s_last on beat 7, m_ready=1 -> m_valid one cycle after beat 7, m_data[127:0]=beat1, m_data[1023:896]=beat8, frame_cnt=1.
REQ-033 SHALL cover: m_ready=0, 3 frames sent back-to-back -> s_ready low at beat 7 of frame 3; after m_ready=1 frames retire in order 1,2,3 with no data loss.
REQ-034 SHALL cover: s_last on beat 3 -> err_short one pulse, no m_valid, next 8 beats form a correct frame.
REQ-035 SHALL cover: 8 beats without s_last -> frame delivered, err_long one pulse.
REQ-036 SHALL cover: reset low after beat 5 with one frame buffered -> all outputs 0 asynchronously, next full frame delivered with frame_cnt=1.
REQ-037 SHALL cover: frame_cnt preloaded path via 65536 frames -> frame_cnt wraps to 0.
